hex_debug_viewer: RTL and testbench

//  Parametrised successor to the board debug display mux. Selects one of N_CH

---
 rtl/hex_debug_viewer.sv | 131 +++++++++++++
 tb/tb_hex_debug_viewer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_debug_viewer.sv
// hex_debug_viewer: selects one of N_CH probe words (manual select or timed
// auto-cycle), optionally freezes a snapshot, and drives N_DIG active-low
// 7-segment hex digits. Display path is two registers deep after the channel
// index register.
module hex_debug_viewer #(
    parameter  int N_CH     = 16,
    parameter  int DATA_W   = 32,
    parameter  int N_DIG    = 8,
    parameter  int DWELL    = 50_000_000,
    parameter  int BLANK_LZ = 0,
    localparam int SEL_W    = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_CH*DATA_W-1:0] ch_data,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   auto_en,
    input  logic                   step,
    input  logic                   freeze,
    output logic [N_DIG*7-1:0]     seg,
    output logic [SEL_W-1:0]       cur_ch,
    output logic                   frozen
);

    localparam int DW_W   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int WORD_W = 4 * N_DIG;

    logic [SEL_W-1:0]  ch_idx;
    logic [DW_W-1:0]   dwell_cnt;
    logic              freeze_q;
    logic              rise;
    logic [WORD_W-1:0] snapshot;
    logic [WORD_W-1:0] live_word;
    logic [WORD_W-1:0] word_q;
    logic [N_DIG*7-1:0] seg_d;
    logic              dwell_done;
    logic [SEL_W-1:0]  ch_next;
    logic              any_nz;
    logic [3:0]        nib;

    logic [DATA_W-1:0] ch_arr [N_CH];

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign ch_arr[k] = ch_data[k*DATA_W +: DATA_W];
    end

    assign cur_ch     = ch_idx;
    assign rise       = freeze & ~freeze_q;
    assign dwell_done = (dwell_cnt == DW_W'(DWELL - 1));
    assign ch_next    = (ch_idx == SEL_W'(N_CH - 1)) ? '0 : ch_idx + 1'b1;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    // Live probe mux; an index beyond the last channel reads as zero.
    always_comb begin
        live_word = '0;
        if ({1'b0, ch_idx} < (SEL_W+1)'(N_CH))
            live_word[DATA_W-1:0] = ch_arr[ch_idx];
    end

    // Channel index and dwell timer; freeze holds both and beats step/expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_idx    <= '0;
            dwell_cnt <= '0;
        end else if (freeze) begin
            ch_idx    <= ch_idx;
            dwell_cnt <= dwell_cnt;
        end else if (!auto_en) begin
            ch_idx    <= sel;
            dwell_cnt <= '0;
        end else if (step || dwell_done) begin
            ch_idx    <= ch_next;
            dwell_cnt <= '0;
        end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

    // Freeze edge detect and snapshot capture of the word being displayed.
    always_ff @(posedge clk) begin
        if (reset) begin
            freeze_q <= 1'b0;
            frozen   <= 1'b0;
            snapshot <= '0;
        end else begin
            freeze_q <= freeze;
            frozen   <= freeze;
            if (rise)
                snapshot <= live_word;
        end
    end

    // Leading-zero blanking scans from the top digit; digit 0 is never blanked.
    always_comb begin
        seg_d  = '1;
        any_nz = 1'b0;
        nib    = '0;
        for (int d = N_DIG - 1; d >= 0; d--) begin
            nib    = word_q[d*4 +: 4];
            any_nz = any_nz | (nib != 4'h0);
            if (BLANK_LZ != 0 && d != 0 && !any_nz)
                seg_d[d*7 +: 7] = 7'h7F;
            else
                seg_d[d*7 +: 7] = hex7(nib);
        end
    end

    // Two-stage display pipeline: word select, then glyph decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            seg    <= '1;
        end else begin
            word_q <= frozen ? snapshot : live_word;
            seg    <= seg_d;
        end
    end

endmodule

// File: tb/tb_hex_debug_viewer.sv
// Directed bench for hex_debug_viewer: a 16-channel unblanked instance for
// select/auto/freeze behaviour and a 12-channel blanking instance for the
// out-of-range select and leading-zero cases.
module tb_hex_debug_viewer;

    logic          clk = 1'b0;
    logic          reset;
    logic [511:0]  ch_data;
    logic [3:0]    sel;
    logic          auto_en, step, freeze;
    logic [55:0]   seg;
    logic [3:0]    cur_ch;
    logic          frozen;

    logic [383:0]  ch_data2;
    logic [3:0]    sel2;
    logic [55:0]   seg2;
    logic [3:0]    cur_ch2;
    logic          frozen2;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [55:0] ALL_BLANK = {8{7'h7F}};

    always #5 clk = ~clk;

    hex_debug_viewer #(.N_CH(16), .DATA_W(32), .N_DIG(8), .DWELL(4), .BLANK_LZ(0)) dut (
        .clk(clk), .reset(reset), .ch_data(ch_data), .sel(sel), .auto_en(auto_en),
        .step(step), .freeze(freeze), .seg(seg), .cur_ch(cur_ch), .frozen(frozen));

    hex_debug_viewer #(.N_CH(12), .DATA_W(32), .N_DIG(8), .DWELL(4), .BLANK_LZ(1)) dut2 (
        .clk(clk), .reset(reset), .ch_data(ch_data2), .sel(sel2), .auto_en(1'b0),
        .step(1'b0), .freeze(1'b0), .seg(seg2), .cur_ch(cur_ch2), .frozen(frozen2));

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
        endcase
    endfunction

    function automatic logic [55:0] seg_of(input logic [31:0] w);
        logic [55:0] r;
        for (int d = 0; d < 8; d++) r[d*7 +: 7] = glyph(w[d*4 +: 4]);
        return r;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        tick(2);
        n_cmp++; if (seg !== ALL_BLANK) begin n_err++; $display("FAIL reset_seg: got %h exp %h", seg, ALL_BLANK); end
        n_cmp++; if (cur_ch !== 4'd0) begin n_err++; $display("FAIL reset_cur_ch: got %0d exp 0", cur_ch); end
        n_cmp++; if (frozen !== 1'b0) begin n_err++; $display("FAIL reset_frozen: got %b exp 0", frozen); end
        n_cmp++; if (seg2 !== ALL_BLANK) begin n_err++; $display("FAIL reset_seg2: got %h exp %h", seg2, ALL_BLANK); end
        reset = 1'b0;
    endtask

    task automatic test_manual;
        for (int k = 0; k < 16; k++) ch_data[k*32 +: 32] = 32'h1111_1111 * k;
        ch_data[3*32 +: 32] = 32'h1234_ABCD;
        sel = 4'd3;
        tick(1);
        n_cmp++; if (cur_ch !== 4'd3) begin n_err++; $display("FAIL manual_cur_ch: got %0d exp 3", cur_ch); end
        tick(2);
        n_cmp++; if (seg[0 +: 7] !== 7'h21) begin n_err++; $display("FAIL manual_digit0: got %h exp 21", seg[0 +: 7]); end
        n_cmp++; if (seg[49 +: 7] !== 7'h79) begin n_err++; $display("FAIL manual_digit7: got %h exp 79", seg[49 +: 7]); end
        n_cmp++; if (seg !== seg_of(32'h1234_ABCD)) begin n_err++; $display("FAIL manual_seg: got %h exp %h", seg, seg_of(32'h1234_ABCD)); end
        ch_data[3*32 +: 32] = 32'hFEDC_0000;
        tick(1);
        n_cmp++; if (seg !== seg_of(32'h1234_ABCD)) begin n_err++; $display("FAIL data_lat1: got %h exp %h", seg, seg_of(32'h1234_ABCD)); end
        tick(1);
        n_cmp++; if (seg !== seg_of(32'hFEDC_0000)) begin n_err++; $display("FAIL data_lat2: got %h exp %h", seg, seg_of(32'hFEDC_0000)); end
    endtask

    task automatic test_out_of_range;
        ch_data2 = '1;
        sel2 = 4'd13;
        tick(3);
        n_cmp++; if (cur_ch2 !== 4'd13) begin n_err++; $display("FAIL oor_cur_ch: got %0d exp 13", cur_ch2); end
        n_cmp++; if (seg2 !== {{7{7'h7F}}, 7'h40}) begin n_err++; $display("FAIL oor_seg: got %h exp %h", seg2, {{7{7'h7F}}, 7'h40}); end
    endtask

    task automatic test_blank_lz;
        sel2 = 4'd1;
        ch_data2[32 +: 32] = 32'h0000_00A0;
        tick(3);
        n_cmp++; if (seg2 !== {{6{7'h7F}}, 7'h08, 7'h40}) begin n_err++; $display("FAIL blank_a0: got %h exp %h", seg2, {{6{7'h7F}}, 7'h08, 7'h40}); end
        ch_data2[32 +: 32] = 32'h0;
        tick(2);
        n_cmp++; if (seg2 !== {{7{7'h7F}}, 7'h40}) begin n_err++; $display("FAIL blank_zero: got %h exp %h", seg2, {{7{7'h7F}}, 7'h40}); end
        ch_data2[32 +: 32] = 32'h0000_1000;
        tick(2);
        n_cmp++; if (seg2 !== {{4{7'h7F}}, 7'h79, 7'h40, 7'h40, 7'h40}) begin n_err++; $display("FAIL blank_inner0: got %h exp %h", seg2, {{4{7'h7F}}, 7'h79, 7'h40, 7'h40, 7'h40}); end
    endtask

    task automatic test_auto;
        sel = 4'd0;
        tick(1);
        auto_en = 1'b1;
        tick(3);
        n_cmp++; if (cur_ch !== 4'd0) begin n_err++; $display("FAIL auto_hold0: got %0d exp 0", cur_ch); end
        tick(1);
        n_cmp++; if (cur_ch !== 4'd1) begin n_err++; $display("FAIL auto_adv1: got %0d exp 1", cur_ch); end
        tick(4);
        n_cmp++; if (cur_ch !== 4'd2) begin n_err++; $display("FAIL auto_adv2: got %0d exp 2", cur_ch); end
        auto_en = 1'b0; sel = 4'd15;
        tick(1);
        auto_en = 1'b1;
        tick(3);
        n_cmp++; if (cur_ch !== 4'd15) begin n_err++; $display("FAIL auto_pre_wrap: got %0d exp 15", cur_ch); end
        tick(1);
        n_cmp++; if (cur_ch !== 4'd0) begin n_err++; $display("FAIL auto_wrap: got %0d exp 0", cur_ch); end
        tick(1);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        n_cmp++; if (cur_ch !== 4'd1) begin n_err++; $display("FAIL auto_step: got %0d exp 1", cur_ch); end
        tick(3);
        n_cmp++; if (cur_ch !== 4'd1) begin n_err++; $display("FAIL step_restart_hold: got %0d exp 1", cur_ch); end
        tick(1);
        n_cmp++; if (cur_ch !== 4'd2) begin n_err++; $display("FAIL step_restart_adv: got %0d exp 2", cur_ch); end
    endtask

    task automatic test_simultaneous;
        tick(3);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        n_cmp++; if (cur_ch !== 4'd3) begin n_err++; $display("FAIL step_and_expiry: got %0d exp 3", cur_ch); end
        tick(3);
        freeze = 1'b1; step = 1'b1;
        tick(1);
        step = 1'b0;
        n_cmp++; if (cur_ch !== 4'd3) begin n_err++; $display("FAIL freeze_vs_step: got %0d exp 3", cur_ch); end
        n_cmp++; if (frozen !== 1'b1) begin n_err++; $display("FAIL freeze_vs_step_frozen: got %b exp 1", frozen); end
        freeze = 1'b0;
        tick(1);
        n_cmp++; if (cur_ch !== 4'd4) begin n_err++; $display("FAIL held_expiry_resume: got %0d exp 4", cur_ch); end
    endtask

    task automatic test_freeze;
        auto_en = 1'b0; sel = 4'd2;
        ch_data[2*32 +: 32] = 32'h5;
        tick(3);
        n_cmp++; if (seg !== seg_of(32'h5)) begin n_err++; $display("FAIL freeze_pre: got %h exp %h", seg, seg_of(32'h5)); end
        auto_en = 1'b1;
        tick(2);
        freeze = 1'b1;
        tick(1);
        n_cmp++; if (frozen !== 1'b1) begin n_err++; $display("FAIL freeze_rise: got %b exp 1", frozen); end
        ch_data[2*32 +: 32] = 32'h9;
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(5);
        n_cmp++; if (seg !== seg_of(32'h5)) begin n_err++; $display("FAIL freeze_hold_seg: got %h exp %h", seg, seg_of(32'h5)); end
        n_cmp++; if (cur_ch !== 4'd2) begin n_err++; $display("FAIL freeze_hold_ch: got %0d exp 2", cur_ch); end
        n_cmp++; if (frozen !== 1'b1) begin n_err++; $display("FAIL freeze_hold_flag: got %b exp 1", frozen); end
        freeze = 1'b0;
        tick(1);
        n_cmp++; if (frozen !== 1'b0) begin n_err++; $display("FAIL release_flag: got %b exp 0", frozen); end
        n_cmp++; if (cur_ch !== 4'd2) begin n_err++; $display("FAIL release_ch: got %0d exp 2", cur_ch); end
        tick(1);
        n_cmp++; if (cur_ch !== 4'd3) begin n_err++; $display("FAIL release_dwell_kept: got %0d exp 3", cur_ch); end
        n_cmp++; if (seg !== seg_of(32'h5)) begin n_err++; $display("FAIL release_seg1: got %h exp %h", seg, seg_of(32'h5)); end
        tick(1);
        n_cmp++; if (seg !== seg_of(32'h9)) begin n_err++; $display("FAIL release_seg2: got %h exp %h", seg, seg_of(32'h9)); end
    endtask

    task automatic test_reset_mid;
        freeze = 1'b1;
        tick(1);
        reset = 1'b1;
        tick(1);
        n_cmp++; if (cur_ch !== 4'd0) begin n_err++; $display("FAIL midreset_ch: got %0d exp 0", cur_ch); end
        n_cmp++; if (frozen !== 1'b0) begin n_err++; $display("FAIL midreset_frozen: got %b exp 0", frozen); end
        n_cmp++; if (seg !== ALL_BLANK) begin n_err++; $display("FAIL midreset_seg: got %h exp %h", seg, ALL_BLANK); end
        reset = 1'b0; freeze = 1'b0; auto_en = 1'b0;
        tick(1);
    endtask

    initial begin
        reset = 1'b1; ch_data = '0; sel = '0; auto_en = 1'b0; step = 1'b0; freeze = 1'b0;
        ch_data2 = '0; sel2 = '0;
        test_reset;
        test_manual;
        test_out_of_range;
        test_blank_lz;
        test_auto;
        test_simultaneous;
        test_freeze;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
